fsm_stream_arbiter: RTL and testbench

//   Shares one generated single-bit Mealy FSM instance between two requesters.

---
 rtl/fsm_stream_arbiter.sv | 152 +++++++++++++++
 tb/tb_fsm_stream_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fsm_stream_arbiter.sv
// fsm_stream_arbiter: shares one single-bit Mealy FSM between two requesters.
// A granted request is fed LSB-first into the FSM, one bit per clk. The FSM's
// registered output is collected into a response word tagged with the owner's id.
// Optional build macro FSM_STAT_EN adds per-requester completed-response counters.
//
// state | meaning
// IDLE  | waiting for a request; round-robin grant, accept on valid&ready
// SHIFT | driving fsm_in with data bit k; capturing fsm_out of step k-1
// DRAIN | one cycle to capture the output of the last step
// RESP  | response held on rsp_* until rsp_ready
module fsm_stream_arbiter #(
  parameter int W     = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_data,
  input  logic [LEN_W-1:0] req0_len,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_data,
  input  logic [LEN_W-1:0] req1_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_data,
  output logic             fsm_in,
  output logic             fsm_step,
  input  logic             fsm_out
`ifdef FSM_STAT_EN
  ,
  output logic [15:0]      stat_cnt0,
  output logic [15:0]      stat_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, RESP} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     data_q, result_q;
  logic [LEN_W-1:0] len_q, k_q;
  logic             id_q, last_q;
  logic             grant, accept;
  logic [W-1:0]     sel_data;
  logic [LEN_W-1:0] sel_len, sel_len_clamped, cap_idx;
  logic             cap_en;

  // Arbitration: a lone valid requester wins; on a tie the one not served last wins
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_q;
    else if (req1_valid)          grant = 1'b1;
    accept          = (state == IDLE) && (req0_valid || req1_valid);
    sel_data        = grant ? req1_data : req0_data;
    sel_len         = grant ? req1_len : req0_len;
    sel_len_clamped = (sel_len > LEN_W'(W)) ? LEN_W'(W) : sel_len;
    // fsm_out reflects the previous step, so capture lags the step index by one
    cap_en  = ((state == SHIFT) && (k_q != '0)) || (state == DRAIN);
    cap_idx = (state == DRAIN) ? (len_q - LEN_W'(1)) : (k_q - LEN_W'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (sel_len_clamped == '0) ? RESP : SHIFT;
      SHIFT:   if (k_q == (len_q - LEN_W'(1))) state_nxt = DRAIN;
      DRAIN:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction datapath: latch request, step counter, result capture, rr pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      len_q    <= '0;
      k_q      <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      last_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (accept) begin
          data_q   <= sel_data;
          len_q    <= sel_len_clamped;
          id_q     <= grant;
          k_q      <= '0;
          result_q <= '0;
        end
        SHIFT:   k_q <= k_q + LEN_W'(1);
        RESP:    if (rsp_ready) last_q <= id_q;
        default: ;
      endcase
      if (cap_en) begin
        for (int i = 0; i < W; i++)
          if (cap_idx == LEN_W'(i)) result_q[i] <= fsm_out;
      end
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    rsp_id     = 1'b0;
    rsp_data   = '0;
    fsm_in     = 1'b0;
    fsm_step   = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid && grant;
      end
      SHIFT: begin
        fsm_step = 1'b1;
        for (int i = 0; i < W; i++)
          if (k_q == LEN_W'(i)) fsm_in = data_q[i];
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_data  = result_q;
      end
      default: ;
    endcase
  end

`ifdef FSM_STAT_EN
  // Completed-response counters, bumped on the response handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else if ((state == RESP) && rsp_ready) begin
      if (id_q) stat_cnt1 <= stat_cnt1 + 16'd1;
      else      stat_cnt0 <= stat_cnt0 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fsm_stream_arbiter.sv
// Testbench for fsm_stream_arbiter with an echo FSM (fsm_out <= fsm_in).
`timescale 1ns/1ps
module tb_fsm_stream_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_data, req1_data, rsp_data;
  logic [3:0] req0_len, req1_len;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic       fsm_in, fsm_step;
  logic       fsm_out = 1'b0;
`ifdef FSM_STAT_EN
  logic [15:0] stat_cnt0, stat_cnt1;
`endif

  int checks = 0;
  int failures = 0;
  bit m_last = 1'b1;
  int m_cnt0 = 0;
  int m_cnt1 = 0;

  always #5 clk = ~clk;

  // echo FSM
  always @(posedge clk) fsm_out <= fsm_in;

  fsm_stream_arbiter #(.W(8), .LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_len(req0_len),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_len(req1_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .fsm_in(fsm_in), .fsm_step(fsm_step), .fsm_out(fsm_out)
`ifdef FSM_STAT_EN
    , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
  );

  typedef struct {
    bit         v0;
    bit         v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] l0;
    logic [3:0] l1;
    int         hold;
    bit         pend;
    bit         eid;
    logic [7:0] edata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int clamp_len(input logic [3:0] l);
    return (l > 4'd8) ? 8 : int'(l);
  endfunction

  function automatic logic [7:0] low_mask(input int n);
    logic [15:0] m;
    m = (16'd1 << n) - 16'd1;
    return m[7:0];
  endfunction

  // One full transaction: offer, check grant, watch the FSM feed, check response, handshake
  task automatic transact(input bit v0, input bit v1, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [3:0] l0, input logic [3:0] l1, input int hold, input bit pend,
                          output bit gid, output logic [7:0] gdata);
    int n, lat, steps, cl;
    bit exp_g;
    logic [7:0] fed, ed, dsel;
    logic [3:0] lsel;
    @(negedge clk);
    req0_valid = v0; req1_valid = v1;
    req0_data = d0; req1_data = d1; req0_len = l0; req1_len = l1;
    rsp_ready = 1'b0;
    #1;
    n = 0;
    while (!((req0_valid && req0_ready) || (req1_valid && req1_ready)) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_timeout", 32'(n < 20), 1);
    chk("ready_onehot", 32'(req0_ready && req1_ready), 0);
    gid = req1_ready;
    exp_g = (v0 && v1) ? ~m_last : v1;
    chk("grant", gid, exp_g);
    dsel = gid ? d1 : d0;
    lsel = gid ? l1 : l0;
    cl = clamp_len(lsel);
    ed = dsel & low_mask(cl);
    @(negedge clk);
    req0_valid = pend; req1_valid = pend;
    lat = 1; steps = 0; fed = '0;
    while (!rsp_valid && lat < 30) begin
      chk("busy_ready", {req0_ready, req1_ready}, 0);
      if (fsm_step) begin
        if (steps < 8) fed[steps] = fsm_in;
        steps++;
      end else begin
        chk("fsm_in_idle", fsm_in, 0);
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, (cl == 0) ? 1 : cl + 2);
    chk("step_count", steps, cl);
    chk("fed_bits", fed, ed);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, exp_g);
    chk("rsp_data", rsp_data, ed);
    gdata = rsp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_id", rsp_id, exp_g);
      chk("hold_data", rsp_data, ed);
      chk("hold_ready", {req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    m_last = gid;
    if (gid) m_cnt1++; else m_cnt0++;
    @(negedge clk);
    chk("rsp_released", rsp_valid, 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    bit gid;
    logic [7:0] gdata;
    bit rv0, rv1;

    tbl[0] = '{1'b1, 1'b0, 8'hA5, 8'h00, 4'd8, 4'd0, 0, 1'b0, 1'b0, 8'hA5};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 8'hFF, 4'd0, 4'd3, 0, 1'b0, 1'b1, 8'h07};
    tbl[2] = '{1'b0, 1'b1, 8'h00, 8'hFF, 4'd0, 4'd12, 0, 1'b0, 1'b1, 8'hFF};
    tbl[3] = '{1'b1, 1'b1, 8'h3C, 8'h11, 4'd5, 4'd2, 0, 1'b0, 1'b0, 8'h1C};
    tbl[4] = '{1'b1, 1'b1, 8'h22, 8'h5A, 4'd3, 4'd4, 0, 1'b0, 1'b1, 8'h0A};
    tbl[5] = '{1'b1, 1'b1, 8'hC3, 8'h00, 4'd6, 4'd0, 0, 1'b0, 1'b0, 8'h03};
    tbl[6] = '{1'b1, 1'b1, 8'h0F, 8'h96, 4'd2, 4'd8, 0, 1'b0, 1'b1, 8'h96};
    tbl[7] = '{1'b1, 1'b0, 8'hFF, 8'h00, 4'd0, 4'd0, 0, 1'b0, 1'b0, 8'h00};
    tbl[8] = '{1'b0, 1'b1, 8'h00, 8'h81, 4'd0, 4'd1, 5, 1'b1, 1'b1, 8'h01};
    tbl[9] = '{1'b1, 1'b0, 8'h66, 8'h00, 4'd9, 4'd0, 0, 1'b0, 1'b0, 8'h66};

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; req0_len = '0; req1_len = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, fsm_in, fsm_step}, 0);
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 10; i++) begin
      transact(tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1, tbl[i].l0, tbl[i].l1,
               tbl[i].hold, tbl[i].pend, gid, gdata);
      chk($sformatf("tbl%0d_id", i), gid, tbl[i].eid);
      chk($sformatf("tbl%0d_data", i), gdata, tbl[i].edata);
    end

    // reset in the middle of a transaction, at SHIFT step 3
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'hA5; req0_len = 4'd8;
    #1;
    chk("mid_rst_accept", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_in_shift", fsm_step, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outputs", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, fsm_in, fsm_step}, 0);
    rst = 1'b0;
    m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("mid_rst_quiet", {rsp_valid, fsm_step}, 0);
    end
    transact(1'b1, 1'b0, 8'h5C, 8'h00, 4'd7, 4'd0, 0, 1'b0, gid, gdata);
    chk("post_rst_data", gdata, 8'h5C);

    // randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      if (!rv0 && !rv1) rv0 = 1'b1;
      transact(rv0, rv1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 12)),
               4'($urandom_range(0, 12)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
               gid, gdata);
    end

`ifdef FSM_STAT_EN
    chk("stat_cnt0", stat_cnt0, m_cnt0);
    chk("stat_cnt1", stat_cnt1, m_cnt1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
